// File: rtl/alu_8bit_pkg.sv
// Shared opcodes and divider state encoding for the 8-bit ALU.
package alu_8bit_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/alu_8bit_div.sv
// Sequential restoring divider: one quotient bit per clock, eight clocks per divide.
// A divide by zero finishes in the launch cycle with q=FF, r=a and dbz raised.
module alu_8bit_div
  import alu_8bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       dbz,
  output div_state_t state
);

  div_state_t state_next;
  logic [7:0] b_reg;
  logic [7:0] quo;
  logic [7:0] rem;
  logic [2:0] cnt;
  logic [8:0] rem_shift;
  logic [8:0] rem_sub;
  logic       fits;
  logic [7:0] rem_next;
  logic [7:0] quo_next;
  logic       zero_div;

  assign zero_div = (b == 8'd0);

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem, quo[7]};
    rem_sub   = rem_shift - {1'b0, b_reg};
    fits      = (rem_shift >= {1'b0, b_reg});
    rem_next  = fits ? rem_sub[7:0] : rem_shift[7:0];
    quo_next  = {quo[6:0], fits};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_next;
  end

  // Operand latch and iteration registers; quo doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_reg <= 8'd0;
      quo   <= 8'd0;
      rem   <= 8'd0;
      cnt   <= 3'd0;
    end else if (state == DIV_IDLE) begin
      if (go && !zero_div) begin
        b_reg <= b;
        quo   <= a;
        rem   <= 8'd0;
        cnt   <= 3'd0;
      end
    end else begin
      quo <= quo_next;
      rem <= rem_next;
      cnt <= cnt + 3'd1;
    end
  end

  // Next-state logic: a zero divisor never enters RUN.
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (go && !zero_div) state_next = DIV_RUN;
      DIV_RUN:  if (cnt == 3'd7)     state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Outputs: done pulses on the edge that should capture q/r.
  always_comb begin
    busy = (state == DIV_RUN);
    dbz  = (state == DIV_IDLE) && go && zero_div;
    done = dbz || ((state == DIV_RUN) && (cnt == 3'd7));
    q    = (state == DIV_RUN) ? quo_next : 8'hFF;
    r    = (state == DIV_RUN) ? rem_next : a;
  end

endmodule

// File: rtl/alu_8bit.sv
// 8-bit ALU: single-cycle add/sub/mul plus a launched multi-cycle divide,
// all results held in output registers with carry/overflow flags.
//
// Divide handshake: start is a level request, qualified by op==DIV and an
// "armed" flag; it is accepted only while busy=0. Once accepted, busy stays
// high until the result edge and instr/start are ignored meanwhile. A new
// divide needs one idle cycle with start low or op!=DIV to re-arm.
module alu_8bit
  import alu_8bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] instr,
  input  logic        start,
  output logic [7:0]  result1,
  output logic [7:0]  result2,
  output logic        carry,
  output logic        overflow,
  output logic        busy
);

  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] prod16;
  logic [7:0]  alu_r1;
  logic [7:0]  alu_r2;
  logic        alu_c;
  logic        alu_v;
  logic        arm;
  logic        go;
  logic        div_busy;
  logic        div_done;
  logic        div_dbz;
  logic [7:0]  div_q;
  logic [7:0]  div_r;
  div_state_t  div_state;
  logic        div_idle;

  assign op       = instr[17:16];
  assign a        = instr[15:8];
  assign b        = instr[7:0];
  assign div_idle = (div_state == DIV_IDLE);
  assign go       = div_idle && (op == OP_DIV) && start && arm;
  assign busy     = div_busy;

  alu_8bit_div u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .a     (a),
    .b     (b),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r),
    .dbz   (div_dbz),
    .state (div_state)
  );

  // Single-cycle arithmetic for the non-divide opcodes.
  always_comb begin
    sum9   = {1'b0, a} + {1'b0, b};
    diff9  = {1'b0, a} - {1'b0, b};
    prod16 = a * b;
    alu_r1 = 8'd0;
    alu_r2 = 8'd0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r1 = sum9[7:0];
        alu_c  = sum9[8];
        alu_v  = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB: begin
        alu_r1 = diff9[7:0];
        alu_c  = diff9[8];
        alu_v  = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      OP_MUL: begin
        alu_r1 = prod16[7:0];
        alu_r2 = prod16[15:8];
        alu_c  = (prod16[15:8] != 8'd0);
        alu_v  = (prod16[15:8] != 8'd0);
      end
      default: ;
    endcase
  end

  // Output registers and launch arming; a divide result wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result1  <= 8'd0;
      result2  <= 8'd0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      arm      <= 1'b1;
    end else begin
      if (div_done) begin
        result1  <= div_q;
        result2  <= div_r;
        carry    <= 1'b0;
        overflow <= div_dbz;
      end else if (div_idle && (op != OP_DIV)) begin
        result1  <= alu_r1;
        result2  <= alu_r2;
        carry    <= alu_c;
        overflow <= alu_v;
      end
      if (div_idle) arm <= !((op == OP_DIV) && start);
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: reset, add/sub/mul vectors, divides, divide by zero,
// start-held no-relaunch and reset in the middle of a divide.
module tb_alu_8bit;
  import alu_8bit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [17:0] instr;
  logic        start;
  logic [7:0]  result1;
  logic [7:0]  result2;
  logic        carry;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .start    (start),
    .result1  (result1),
    .result2  (result2),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one single-cycle op and check the registered result after one edge.
  task automatic alu_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] e1, input logic [7:0] e2,
                        input logic ec, input logic ev);
    instr = {op, a, b};
    start = 1'b0;
    tick();
    chk({tag, "_r1"}, result1, e1);
    chk({tag, "_r2"}, result2, e2);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_v"}, overflow, ev);
  endtask

  // Launch a divide and follow it to completion.
  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input bit hold_start);
    logic [7:0] prev1;
    int n;
    instr = {OP_DIV, a, b};
    start = 1'b0;
    prev1 = result1;
    tick();
    chk({tag, "_idle_hold"}, result1, prev1);
    start = 1'b1;
    tick();
    chk({tag, "_busy_rise"}, busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
      if (n == 2) chk({tag, "_mid_hold"}, result1, prev1);
      if (n == 3 && !hold_start) start = 1'b0;
      if (n == 4) instr = {OP_DIV, 8'h11, 8'h22};
    end
    chk({tag, "_busy_cycles"}, n, 8);
    chk({tag, "_q"}, result1, eq);
    chk({tag, "_r"}, result2, er);
    chk({tag, "_c"}, carry, 1'b0);
    chk({tag, "_v"}, overflow, 1'b0);
    if (hold_start) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk({tag, "_no_relaunch_busy"}, busy, 1'b0);
        chk({tag, "_no_relaunch_q"}, result1, eq);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    instr = 18'd0;
    start = 1'b0;
    tick();
    tick();
    chk("rst_r1", result1, 8'd0);
    chk("rst_r2", result2, 8'd0);
    chk("rst_c", carry, 1'b0);
    chk("rst_v", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    alu_op("add_2_1", OP_ADD, 8'd2, 8'd1, 8'd3, 8'd0, 1'b0, 1'b0);
    alu_op("add_ff_ff", OP_ADD, 8'd255, 8'd255, 8'hFE, 8'd0, 1'b1, 1'b0);
    alu_op("add_7f_1", OP_ADD, 8'd127, 8'd1, 8'h80, 8'd0, 1'b0, 1'b1);
    alu_op("sub_2_1", OP_SUB, 8'd2, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0);
    alu_op("sub_ff_5", OP_SUB, 8'd255, 8'd5, 8'hFA, 8'd0, 1'b0, 1'b0);
    alu_op("sub_1_2", OP_SUB, 8'd1, 8'd2, 8'hFF, 8'd0, 1'b1, 1'b0);
    alu_op("mul_8_2", OP_MUL, 8'd8, 8'd2, 8'd16, 8'd0, 1'b0, 1'b0);
    alu_op("mul_ff_5", OP_MUL, 8'd255, 8'd5, 8'hFB, 8'h04, 1'b1, 1'b1);

    do_div("div_2_1", 8'd2, 8'd1, 8'd2, 8'd0, 1'b0);
    do_div("div_8_2", 8'd8, 8'd2, 8'd4, 8'd0, 1'b0);
    do_div("div_255_5", 8'd255, 8'd5, 8'd51, 8'd0, 1'b0);
    do_div("div_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b1);
    do_div("div_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

    // Divide by zero: one idle cycle with start low, then launch.
    instr = {OP_DIV, 8'd7, 8'd0};
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("dbz_r1", result1, 8'hFF);
    chk("dbz_r2", result2, 8'd7);
    chk("dbz_v", overflow, 1'b1);
    chk("dbz_c", carry, 1'b0);
    chk("dbz_busy", busy, 1'b0);
    start = 1'b0;

    // Reset in the middle of a divide.
    alu_op("pre_rst_add", OP_ADD, 8'd10, 8'd20, 8'd30, 8'd0, 1'b0, 1'b0);
    instr = {OP_DIV, 8'd255, 8'd5};
    start = 1'b1;
    tick();
    chk("mid_busy", busy, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_r1", result1, 8'd0);
    chk("mid_rst_r2", result2, 8'd0);
    chk("mid_rst_c", carry, 1'b0);
    chk("mid_rst_v", overflow, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    alu_op("post_rst_add", OP_ADD, 8'd2, 8'd1, 8'd3, 8'd0, 1'b0, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
